// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS datapath.
// Control encodings, opcodes and the immediate helper.
package mips_pkg;

    localparam int WIDTH = 32;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_HOLD   = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/datapath_regs_flopenr.sv
// Enabled register with asynchronous active-low reset value.
// Used for every state element in the datapath.
module flopenr #(
    parameter int           W    = 32,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d when enabled; reset forces INIT at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= INIT;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/datapath_regs.sv
// Multicycle MIPS register stage: PC, IR, MDR, A, B, ALUOut,
// operand muxes, field decode and a retired-fetch counter.
module datapath_regs #(
    parameter int          WIDTH      = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] COUNT_INIT = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IorD,
    input  logic             IRWrite,
    input  logic             PCWrite,
    input  logic             BranchEQ,
    input  logic             BranchNE,
    input  logic [1:0]       PCSrc,
    input  logic             ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic [WIDTH-1:0] rf_rd1,
    input  logic [WIDTH-1:0] rf_rd2,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [WIDTH-1:0] instr,
    output logic [5:0]       opcode,
    output logic [5:0]       funct,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [WIDTH-1:0] imm_sext,
    output logic [WIDTH-1:0] mdr,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] src_a,
    output logic [WIDTH-1:0] src_b,
    output logic [31:0]      instr_count,
    output logic             pc_misaligned
);

    import mips_pkg::*;

    logic             pc_en;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [31:0]      count_next;

    assign pc_en = PCWrite
                 | (BranchEQ & alu_zero)
                 | (BranchNE & ~alu_zero);

    // Select the PC source; the jump target keeps the
    // upper nibble of the already-incremented pc.
    always_comb begin
        next_pc = pc;
        unique case (PCSrc)
            PC_ALU:    next_pc = alu_result;
            PC_ALUOUT: next_pc = alu_out;
            PC_JUMP:   next_pc = {pc[31:28], instr[25:0], 2'b00};
            PC_HOLD:   next_pc = pc;
            default:   next_pc = pc;
        endcase
    end

    flopenr #(.W(WIDTH), .INIT(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .en(pc_en),
        .d(next_pc), .q(pc)
    );

    flopenr #(.W(WIDTH)) u_ir (
        .clk(clk), .rst(rst), .en(IRWrite),
        .d(mem_rdata), .q(instr)
    );

    assign count_next = instr_count + 32'd1;

    flopenr #(.W(32), .INIT(COUNT_INIT)) u_cnt (
        .clk(clk), .rst(rst), .en(IRWrite),
        .d(count_next), .q(instr_count)
    );

    flopenr #(.W(WIDTH)) u_mdr (
        .clk(clk), .rst(rst), .en(1'b1),
        .d(mem_rdata), .q(mdr)
    );

    flopenr #(.W(WIDTH)) u_a (
        .clk(clk), .rst(rst), .en(1'b1),
        .d(rf_rd1), .q(a_reg)
    );

    flopenr #(.W(WIDTH)) u_b (
        .clk(clk), .rst(rst), .en(1'b1),
        .d(rf_rd2), .q(b_reg)
    );

    flopenr #(.W(WIDTH)) u_aluout (
        .clk(clk), .rst(rst), .en(1'b1),
        .d(alu_result), .q(alu_out)
    );

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign imm_sext = sext16(instr[15:0]);

    assign mem_addr      = IorD ? alu_out : pc;
    assign mem_wdata     = b_reg;
    assign src_a         = ALUSrcA ? a_reg : pc;
    assign pc_misaligned = |pc[1:0];

    // Second ALU operand: register, +4, or immediate forms.
    always_comb begin
        src_b = b_reg;
        unique case (ALUSrcB)
            SRCB_REG:     src_b = b_reg;
            SRCB_FOUR:    src_b = 32'd4;
            SRCB_IMM:     src_b = imm_sext;
            SRCB_IMM_SH2: src_b = {imm_sext[29:0], 2'b00};
            default:      src_b = b_reg;
        endcase
    end

endmodule

// File: tb/tb_datapath_regs.sv
// Bench for datapath_regs: directed sequences, a mux vector
// table and random cycles against a behavioural model.
module tb_datapath_regs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic IorD = 0, IRWrite = 0, PCWrite = 0;
    logic BranchEQ = 0, BranchNE = 0, alu_zero = 0;
    logic ALUSrcA = 0;
    logic [1:0] PCSrc = 0, ALUSrcB = 0;
    logic [31:0] mem_rdata = 0, alu_result = 0;
    logic [31:0] rf_rd1 = 0, rf_rd2 = 0;

    logic [31:0] pc, mem_addr, mem_wdata, instr, imm_sext;
    logic [31:0] mdr, alu_out, src_a, src_b, instr_count;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic        pc_misaligned;

    logic [31:0] d2_pc, d2_mem_addr, d2_mem_wdata, d2_instr;
    logic [31:0] d2_imm_sext, d2_mdr, d2_alu_out, d2_src_a;
    logic [31:0] d2_src_b, d2_instr_count;
    logic [5:0]  d2_opcode, d2_funct;
    logic [4:0]  d2_rs, d2_rt, d2_rd;
    logic        d2_pc_misaligned;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    datapath_regs #(.RESET_PC(32'h0000_0040)) dut (
        .clk(clk), .rst(rst), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .BranchEQ(BranchEQ), .BranchNE(BranchNE),
        .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .mem_rdata(mem_rdata), .alu_result(alu_result),
        .alu_zero(alu_zero), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .pc(pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .instr(instr), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .imm_sext(imm_sext),
        .mdr(mdr), .alu_out(alu_out), .src_a(src_a),
        .src_b(src_b), .instr_count(instr_count),
        .pc_misaligned(pc_misaligned)
    );

    datapath_regs #(
        .RESET_PC(32'h0000_0040),
        .COUNT_INIT(32'hFFFF_FFFF)
    ) dut2 (
        .clk(clk), .rst(rst), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .BranchEQ(BranchEQ), .BranchNE(BranchNE),
        .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .mem_rdata(mem_rdata), .alu_result(alu_result),
        .alu_zero(alu_zero), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .pc(d2_pc), .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata),
        .instr(d2_instr), .opcode(d2_opcode), .funct(d2_funct),
        .rs(d2_rs), .rt(d2_rt), .rd(d2_rd), .imm_sext(d2_imm_sext),
        .mdr(d2_mdr), .alu_out(d2_alu_out), .src_a(d2_src_a),
        .src_b(d2_src_b), .instr_count(d2_instr_count),
        .pc_misaligned(d2_pc_misaligned)
    );

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_mdr, m_a, m_b, m_ao, m_cnt;

    task automatic model_reset();
        m_pc = 32'h40;
        m_instr = 0; m_mdr = 0; m_a = 0; m_b = 0; m_ao = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] m_imm();
        logic [31:0] lo;
        lo = m_instr & 32'hFFFF;
        if (lo >= 32'h8000) return lo - 32'h10000;
        return lo;
    endfunction

    task automatic model_edge();
        bit take;
        logic [31:0] nxt;
        take = PCWrite || (BranchEQ && alu_zero) || (BranchNE && !alu_zero);
        if (PCSrc == 0)      nxt = alu_result;
        else if (PCSrc == 1) nxt = m_ao;
        else if (PCSrc == 2)
            nxt = (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
        else                 nxt = m_pc;
        if (take) m_pc = nxt;
        if (IRWrite) begin
            m_instr = mem_rdata;
            m_cnt = m_cnt + 1;
        end
        m_mdr = mem_rdata;
        m_a = rf_rd1;
        m_b = rf_rd2;
        m_ao = alu_result;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] sb;
        if (ALUSrcB == 0)      sb = m_b;
        else if (ALUSrcB == 1) sb = 4;
        else if (ALUSrcB == 2) sb = m_imm();
        else                   sb = m_imm() * 4;
        chk("pc", pc, m_pc);
        chk("instr", instr, m_instr);
        chk("opcode", 32'(opcode), m_instr / 32'h0400_0000);
        chk("rs", 32'(rs), (m_instr / 32'h20_0000) % 32);
        chk("rt", 32'(rt), (m_instr / 32'h1_0000) % 32);
        chk("rd", 32'(rd), (m_instr / 32'h800) % 32);
        chk("funct", 32'(funct), m_instr % 64);
        chk("imm_sext", imm_sext, m_imm());
        chk("mdr", mdr, m_mdr);
        chk("alu_out", alu_out, m_ao);
        chk("mem_wdata", mem_wdata, m_b);
        chk("instr_count", instr_count, m_cnt);
        chk("pc_misaligned", 32'(pc_misaligned), 32'(m_pc % 4 != 0));
        chk("mem_addr", mem_addr, IorD ? m_ao : m_pc);
        chk("src_a", src_a, ALUSrcA ? m_a : m_pc);
        chk("src_b", src_b, sb);
    endtask

    task automatic idle();
        IorD = 0; IRWrite = 0; PCWrite = 0;
        BranchEQ = 0; BranchNE = 0; alu_zero = 0;
        PCSrc = 0; ALUSrcA = 0; ALUSrcB = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic load_aluout(input logic [31:0] v);
        idle();
        alu_result = v;
        tick();
    endtask

    typedef struct {
        logic        iord;
        logic        asel;
        logic [1:0]  bsel;
        logic [31:0] e_addr;
        logic [31:0] e_a;
        logic [31:0] e_b;
    } mux_vec_t;

    mux_vec_t vecs[4];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 2'b00, 32'h40, 32'h40, 32'h2222_0000};
        vecs[1] = '{1'b1, 1'b1, 2'b01, 32'h3333_0000, 32'h1111_0000, 32'h4};
        vecs[2] = '{1'b0, 1'b1, 2'b10, 32'h40, 32'h1111_0000, 32'hFFFF_FFFC};
        vecs[3] = '{1'b1, 1'b0, 2'b11, 32'h3333_0000, 32'h40, 32'hFFFF_FFF0};

        model_reset();
        idle();
        #1 rst = 1'b0;
        #11;
        chk("rst_pc", pc, 32'h40);
        chk("rst_instr", instr, 32'h0);
        chk("rst_count", instr_count, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h40);
        chk("rst_misaligned", 32'(pc_misaligned), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Fetch
        mem_rdata = 32'h2008_0005;
        IRWrite = 1; PCWrite = 1; PCSrc = 2'b00;
        alu_result = 32'h44;
        tick();
        idle();
        chk("fetch_instr", instr, 32'h2008_0005);
        chk("fetch_pc", pc, 32'h44);
        chk("fetch_opcode", 32'(opcode), 32'h08);
        chk("fetch_rt", 32'(rt), 32'd8);
        chk("fetch_imm", imm_sext, 32'h5);
        chk("fetch_count", instr_count, 32'd1);

        // Branches
        load_aluout(32'h80);
        BranchEQ = 1; PCSrc = 2'b01; alu_zero = 1;
        alu_result = 32'hDEAD_0000;
        tick();
        chk("beq_taken", pc, 32'h80);
        load_aluout(32'hC0);
        BranchEQ = 1; PCSrc = 2'b01; alu_zero = 0;
        tick();
        chk("beq_not_taken", pc, 32'h80);
        load_aluout(32'h100);
        BranchNE = 1; PCSrc = 2'b01; alu_zero = 0;
        tick();
        chk("bne_taken", pc, 32'h100);
        load_aluout(32'h140);
        BranchNE = 1; PCSrc = 2'b01; alu_zero = 1;
        tick();
        chk("bne_not_taken", pc, 32'h100);
        load_aluout(32'h180);
        BranchEQ = 1; BranchNE = 1; PCSrc = 2'b01; alu_zero = 1;
        tick();
        chk("both_branch", pc, 32'h180);

        // Jump
        idle();
        mem_rdata = 32'h0800_0010;
        IRWrite = 1; PCWrite = 1; PCSrc = 2'b00;
        alu_result = 32'h1000_0008;
        tick();
        idle();
        PCWrite = 1; PCSrc = 2'b10;
        tick();
        chk("jump_pc", pc, 32'h1000_0040);

        // Hold encoding and misaligned target
        idle();
        PCWrite = 1; PCSrc = 2'b11; alu_result = 32'h1234_5678;
        tick();
        chk("hold_pc", pc, 32'h1000_0040);
        idle();
        PCWrite = 1; PCSrc = 2'b00; alu_result = 32'h1000_0042;
        tick();
        chk("misaligned_pc", pc, 32'h1000_0042);
        chk("misaligned_flag", 32'(pc_misaligned), 32'h1);
        idle();
        #1;
        check_all();

        // Random cycles against the model
        for (int i = 0; i < 300; i++) begin
            IorD = 1'($urandom);
            IRWrite = 1'($urandom);
            PCWrite = ($urandom_range(0, 3) == 0);
            BranchEQ = ($urandom_range(0, 3) == 0);
            BranchNE = ($urandom_range(0, 3) == 0);
            alu_zero = 1'($urandom);
            PCSrc = 2'($urandom);
            ALUSrcA = 1'($urandom);
            ALUSrcB = 2'($urandom);
            mem_rdata = $urandom;
            alu_result = $urandom;
            rf_rd1 = $urandom;
            rf_rd2 = $urandom;
            #1;
            check_all();
            tick();
        end

        // Reset in the middle of a cycle
        @(posedge clk);
        #3;
        idle();
        rst = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_pc", pc, 32'h40);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_count", instr_count, 32'h0);
        chk("mid_rst_mem_addr", mem_addr, 32'h40);
        chk("mid_rst_misaligned", 32'(pc_misaligned), 32'h0);
        chk("mid_rst_aluout", alu_out, 32'h0);
        chk("wrap_init", d2_instr_count, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b1;

        // Operand mux table
        rf_rd1 = 32'h1111_0000;
        rf_rd2 = 32'h2222_0000;
        alu_result = 32'h3333_0000;
        mem_rdata = 32'h2008_FFFC;
        IRWrite = 1;
        tick();
        idle();
        chk("wrap_zero", d2_instr_count, 32'h0);
        chk("no_wrap", instr_count, 32'h1);
        rf_rd1 = 32'hAAAA_AAAA;
        rf_rd2 = 32'h5555_5555;
        alu_result = 32'h7777_7777;
        for (int i = 0; i < 4; i++) begin
            IorD = vecs[i].iord;
            ALUSrcA = vecs[i].asel;
            ALUSrcB = vecs[i].bsel;
            #1;
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_src_a", i), src_a, vecs[i].e_a);
            chk($sformatf("vec%0d_src_b", i), src_b, vecs[i].e_b);
        end
        chk("mux_wdata", mem_wdata, 32'h2222_0000);
        check_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
